// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_pkg
// Description : Shared constants, FSM state type and frame helper for the
//               SD CMD-line frame builder.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam int CMD_FRAME_W  = 48;
    localparam int CMD_CRC_SPAN = 40;

    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    localparam logic START_BIT = 1'b0;
    localparam logic TX_BIT    = 1'b1;
    localparam logic END_BIT   = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CRC   = 2'd1,
        VALID = 2'd2
    } cmd_state_t;

    // Frame word S is MSB-first; the serializer shifts out bit 0 first,
    // so the presented frame is S bit-reversed.
    function automatic logic [CMD_FRAME_W-1:0] reverse_frame(
        input logic [CMD_FRAME_W-1:0] s
    );
        logic [CMD_FRAME_W-1:0] r;
        r = '0;
        for (int k = 0; k < CMD_FRAME_W; k++) begin
            r[k] = s[CMD_FRAME_W-1-k];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc7_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc7_serial
// Description : Combinational CRC7 next-state for N message bits, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module crc7_serial
    import cmd_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [6:0]   crc_in,
    input  logic [N-1:0] data_in,
    output logic [6:0]   crc_out
);

    logic [6:0] c;
    logic       fb;

    // Unrolled LFSR: data_in[N-1] is the earliest bit on the line
    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            fb = c[6] ^ data_in[i];
            c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
        crc_out = c;
    end

endmodule
`default_nettype wire

// File: rtl/cmd_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : cmd_frame_builder
// Description : Builds a 48-bit SD CMD frame (start, tx, index, argument,
//               CRC7, end) and holds it for the serializer until completion
//               or TX timeout.
//               Optional macro CMD_FRAME_BUILDER_CRC_OVERRIDE_EN adds
//               iCrc_Override / iCrc_Value to bypass the CRC computation.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_frame_builder
    import cmd_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int TX_TIMEOUT     = 255
) (
    input  logic                   iClock_SD,
    input  logic                   iReset,
    input  logic                   iStart,
    input  logic [5:0]             iCmd_Index,
    input  logic [31:0]            iArgument,
`ifdef CMD_FRAME_BUILDER_CRC_OVERRIDE_EN
    input  logic                   iCrc_Override,
    input  logic [6:0]             iCrc_Value,
`endif
    input  logic                   iTx_Complete,
    output logic [CMD_FRAME_W-1:0] oFrame,
    output logic                   oFrame_Valid,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oError
);

    localparam int STEPS = CMD_CRC_SPAN / BITS_PER_CYCLE;
    localparam int TW    = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);

    cmd_state_t              state;
    logic [CMD_CRC_SPAN-1:0] msg;
    logic [CMD_CRC_SPAN-1:0] shreg;
    logic [6:0]              crc;
    logic [6:0]              crc_next;
    logic [5:0]              cnt;
    logic [TW-1:0]           tcnt;
    logic                    use_ovr;
    logic [6:0]              ovr_crc;
    logic [5:0]              step_limit;
    logic [6:0]              crc_field;

    crc7_serial #(
        .N(BITS_PER_CYCLE)
    ) u_crc (
        .crc_in  (crc),
        .data_in (shreg[CMD_CRC_SPAN-1 -: BITS_PER_CYCLE]),
        .crc_out (crc_next)
    );

`ifdef CMD_FRAME_BUILDER_CRC_OVERRIDE_EN
    logic       ovr_q;
    logic [6:0] ovr_val_q;

    // Override controls are captured together with the command
    always_ff @(posedge iClock_SD or posedge iReset) begin
        if (iReset) begin
            ovr_q     <= 1'b0;
            ovr_val_q <= 7'h00;
        end else if (state == IDLE && iStart) begin
            ovr_q     <= iCrc_Override;
            ovr_val_q <= iCrc_Value;
        end
    end

    assign use_ovr = ovr_q;
    assign ovr_crc = ovr_val_q;
`else
    assign use_ovr = 1'b0;
    assign ovr_crc = 7'h00;
`endif

    // An overridden CRC spends a single cycle in CRC before the frame loads
    assign step_limit = use_ovr ? 6'd1 : 6'(STEPS);
    assign crc_field  = use_ovr ? ovr_crc : crc;

    // Frame FSM: latch command, step the CRC, present frame, await completion
    always_ff @(posedge iClock_SD or posedge iReset) begin
        if (iReset) begin
            state        <= IDLE;
            msg          <= '0;
            shreg        <= '0;
            crc          <= 7'h00;
            cnt          <= 6'd0;
            tcnt         <= '0;
            oFrame       <= '0;
            oFrame_Valid <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oError       <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        msg   <= {START_BIT, TX_BIT, iCmd_Index, iArgument};
                        shreg <= {START_BIT, TX_BIT, iCmd_Index, iArgument};
                        crc   <= 7'h00;
                        cnt   <= 6'd0;
                        oBusy <= 1'b1;
                        state <= CRC;
                    end
                end
                CRC: begin
                    if (cnt == step_limit) begin
                        oFrame       <= reverse_frame({msg, crc_field, END_BIT});
                        oFrame_Valid <= 1'b1;
                        tcnt         <= '0;
                        state        <= VALID;
                    end else begin
                        crc   <= crc_next;
                        shreg <= shreg << BITS_PER_CYCLE;
                        cnt   <= cnt + 6'd1;
                    end
                end
                VALID: begin
                    // Completion takes priority over a coincident timeout
                    if (iTx_Complete) begin
                        oFrame_Valid <= 1'b0;
                        oBusy        <= 1'b0;
                        oDone        <= 1'b1;
                        state        <= IDLE;
                    end else if (TX_TIMEOUT > 0 && tcnt == TO_LAST) begin
                        oFrame_Valid <= 1'b0;
                        oBusy        <= 1'b0;
                        oError       <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_frame_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_frame_builder
// Description : Scoreboard bench for cmd_frame_builder. Instance A uses
//               BITS_PER_CYCLE=1 / TX_TIMEOUT=10, instance B uses
//               BITS_PER_CYCLE=8 / TX_TIMEOUT=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_frame_builder;

    localparam logic [47:0] S_CMD0  = 48'h40_0000_0000_95;
    localparam logic [47:0] S_CMD8  = 48'h48_0000_01AA_87;
    localparam logic [47:0] S_CMD55 = 48'h77_0000_0000_65;
    localparam logic [47:0] S_CMD41 = 48'h69_4000_0000_77;
    localparam logic [47:0] S_CMD58 = 48'h7A_0000_0000_FD;
    localparam logic [47:0] S_OVR0  = 48'h40_0000_0000_01;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        start_a, start_b, cmpl_a, cmpl_b;
    logic        ovr;
    logic [6:0]  ovr_val;

    logic [47:0] frame_a, frame_b;
    logic        valid_a, busy_a, done_a, err_a;
    logic        valid_b, busy_b, done_b, err_b;

    always #5 clk = ~clk;

    cmd_frame_builder #(.BITS_PER_CYCLE(1), .TX_TIMEOUT(10)) dut_a (
        .iClock_SD    (clk),
        .iReset       (rst),
        .iStart       (start_a),
        .iCmd_Index   (idx),
        .iArgument    (arg),
`ifdef CMD_FRAME_BUILDER_CRC_OVERRIDE_EN
        .iCrc_Override(ovr),
        .iCrc_Value   (ovr_val),
`endif
        .iTx_Complete (cmpl_a),
        .oFrame       (frame_a),
        .oFrame_Valid (valid_a),
        .oBusy        (busy_a),
        .oDone        (done_a),
        .oError       (err_a)
    );

    cmd_frame_builder #(.BITS_PER_CYCLE(8), .TX_TIMEOUT(0)) dut_b (
        .iClock_SD    (clk),
        .iReset       (rst),
        .iStart       (start_b),
        .iCmd_Index   (idx),
        .iArgument    (arg),
`ifdef CMD_FRAME_BUILDER_CRC_OVERRIDE_EN
        .iCrc_Override(1'b0),
        .iCrc_Value   (7'h00),
`endif
        .iTx_Complete (cmpl_b),
        .oFrame       (frame_b),
        .oFrame_Valid (valid_b),
        .oBusy        (busy_b),
        .oDone        (done_b),
        .oError       (err_b)
    );

    typedef struct {
        logic [47:0] frame;
        int          lat;
        bit          exp_done;
        int          start_cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t cur[2];
    bit   prev_valid[2];
    bit   awaiting[2];
    int   rise_cyc[2];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] rev48(input logic [47:0] s);
        logic [47:0] r;
        for (int k = 0; k < 48; k++) r[k] = s[47-k];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected frame on each oFrame_Valid rise and
    // verifies the completion/timeout pulse that ends it.
    task automatic mon(input int id, input logic r, input logic v, input logic b,
                       input logic d, input logic e, input logic [47:0] f);
        exp_t x;
        if (r) begin
            prev_valid[id] = 1'b0;
            awaiting[id]   = 1'b0;
            return;
        end
        if (v && !prev_valid[id]) begin
            if ((id == 0 ? q_a.size() : q_b.size()) == 0) begin
                check($sformatf("unexpected_valid_%0d", id), 64'd1, 64'd0);
            end else begin
                x = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                cur[id] = x;
                check($sformatf("frame_%0d", id), f, x.frame);
                check($sformatf("latency_%0d", id), 64'(cyc - x.start_cyc), 64'(x.lat));
                awaiting[id] = 1'b1;
                rise_cyc[id] = cyc;
            end
        end
        if (d || e) begin
            if (!awaiting[id]) begin
                check($sformatf("unexpected_pulse_%0d", id), {62'd0, d, e}, 64'd0);
            end else begin
                check($sformatf("outcome_%0d", id), {62'd0, d, e},
                      cur[id].exp_done ? 64'd2 : 64'd1);
                check($sformatf("frame_hold_%0d", id), f, cur[id].frame);
                check($sformatf("idle_outputs_%0d", id), {62'd0, v, b}, 64'd0);
                if (e) check($sformatf("timeout_lat_%0d", id), 64'(cyc - rise_cyc[id]), 64'd10);
                awaiting[id] = 1'b0;
            end
        end
        prev_valid[id] = v;
    endtask

    always @(negedge clk) mon(0, rst, valid_a, busy_a, done_a, err_a, frame_a);
    always @(negedge clk) mon(1, rst, valid_b, busy_b, done_b, err_b, frame_b);

    task automatic start_frame(input int id, input logic [5:0] i, input logic [31:0] a,
                               input logic [47:0] s, input int lat, input bit push,
                               input bit exp_done);
        exp_t x;
        @(negedge clk);
        idx = i;
        arg = a;
        if (id == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check($sformatf("busy_rise_%0d", id), {63'd0, (id == 0) ? busy_a : busy_b}, 64'd1);
        if (push) begin
            x.frame     = rev48(s);
            x.lat       = lat;
            x.exp_done  = exp_done;
            x.start_cyc = cyc;
            if (id == 0) q_a.push_back(x); else q_b.push_back(x);
        end
    endtask

    task automatic pulse_start(input int id, input logic [5:0] i);
        @(negedge clk);
        idx = i;
        arg = 32'hDEAD_BEEF;
        if (id == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic complete(input int id);
        @(negedge clk);
        if (id == 0) cmpl_a = 1'b1; else cmpl_b = 1'b1;
        @(posedge clk);
        #1;
        cmpl_a = 1'b0;
        cmpl_b = 1'b0;
    endtask

    task automatic wait_valid(input int id, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((id == 0) ? valid_a : valid_b) && n < budget);
        if (!((id == 0) ? valid_a : valid_b))
            check($sformatf("valid_wait_expired_%0d", id), 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int id, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((id == 0) ? busy_a : busy_b) && n < budget);
        if ((id == 0) ? busy_a : busy_b)
            check($sformatf("idle_wait_expired_%0d", id), 64'd1, 64'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check(name, {11'd0, frame_a, valid_a, busy_a, done_a, err_a}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; idx = '0; arg = '0;
        start_a = 1'b0; start_b = 1'b0; cmpl_a = 1'b0; cmpl_b = 1'b0;
        ovr = 1'b0; ovr_val = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {11'd0, frame_a, valid_a, busy_a, done_a, err_a}, 64'd0);
        check("reset_b", {11'd0, frame_b, valid_b, busy_b, done_b, err_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // CMD0, with a stray completion during CRC that must be ignored
        start_frame(0, 6'd0, 32'h0, S_CMD0, 41, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        complete(0);
        wait_valid(0, 60);
        complete(0);
        wait_idle(0, 5);

        // CMD8 on both widths: identical frame, latency 41 vs 6
        start_frame(0, 6'd8, 32'h0000_01AA, S_CMD8, 41, 1'b1, 1'b1);
        wait_valid(0, 60);
        complete(0);
        wait_idle(0, 5);
        start_frame(1, 6'd8, 32'h0000_01AA, S_CMD8, 6, 1'b1, 1'b1);
        wait_valid(1, 20);
        repeat (20) @(negedge clk);
        complete(1);
        wait_idle(1, 5);

        // Starts during CRC and VALID are ignored; back-to-back after oDone
        start_frame(0, 6'd55, 32'h0, S_CMD55, 41, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        pulse_start(0, 6'd58);
        wait_valid(0, 60);
        pulse_start(0, 6'd58);
        complete(0);
        start_frame(0, 6'd58, 32'h0, S_CMD58, 41, 1'b1, 1'b1);
        wait_valid(0, 60);
        complete(0);
        wait_idle(0, 5);

        // Timeout with no completion
        start_frame(0, 6'd41, 32'h4000_0000, S_CMD41, 41, 1'b1, 1'b0);
        wait_valid(0, 60);
        wait_idle(0, 30);

        // Completion on the expiry cycle wins over the timeout
        start_frame(0, 6'd0, 32'h0, S_CMD0, 41, 1'b1, 1'b1);
        wait_valid(0, 60);
        repeat (9) @(negedge clk);
        cmpl_a = 1'b1;
        @(posedge clk);
        #1;
        cmpl_a = 1'b0;
        wait_idle(0, 5);

        // Reset during CRC, then during VALID; command afterwards is clean
        start_frame(0, 6'd8, 32'h0000_01AA, S_CMD8, 41, 1'b0, 1'b1);
        repeat (15) @(negedge clk);
        do_reset("reset_in_crc");
        start_frame(0, 6'd55, 32'h0, S_CMD55, 41, 1'b1, 1'b1);
        wait_valid(0, 60);
        do_reset("reset_in_valid");
        repeat (3) @(negedge clk);
        start_frame(0, 6'd0, 32'h0, S_CMD0, 41, 1'b1, 1'b1);
        wait_valid(0, 60);
        complete(0);
        wait_idle(0, 5);

`ifdef CMD_FRAME_BUILDER_CRC_OVERRIDE_EN
        // Precomputed CRC of 0 on CMD0: end byte 0x01, valid two cycles later
        ovr = 1'b1;
        ovr_val = 7'h00;
        start_frame(0, 6'd0, 32'h0, S_OVR0, 2, 1'b1, 1'b1);
        ovr = 1'b0;
        wait_valid(0, 10);
        complete(0);
        wait_idle(0, 5);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
        check("no_open_frame", {62'd0, awaiting[0], awaiting[1]}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_frame_builder.md
Name: cmd_frame_builder

Overview:
Assembles a 48-bit SD CMD-line command frame from a 6-bit command index and a 32-bit argument. Computes CRC7 over the first 40 frame bits, one or more bits per cycle. Presents the finished frame to the downstream parallel-to-serial converter and holds it until that converter reports completion. Sits directly upstream of parallel_serial in the CMD path.

Parameters:
BITS_PER_CYCLE, 1, CRC bits processed per clock; legal values 1, 2, 4, 5, 8 (must divide 40).
TX_TIMEOUT, 255, max cycles in VALID waiting for iTx_Complete before abort; 0 disables the timeout.

Ports:
iClock_SD  input  1  CMD-path clock
iReset  input  1  asynchronous, active-high reset
iStart  input  1  request to build a frame; sampled only in IDLE
iCmd_Index  input  6  command index, latched on accepted iStart
iArgument  input  32  command argument, latched on accepted iStart
iTx_Complete  input  1  completion from serializer (its oComplete)
oFrame  output  48  frame; oFrame[k] is the k-th transmitted bit
oFrame_Valid  output  1  frame stable and ready; drives serializer iEnable
oBusy  output  1  high in every state except IDLE
oDone  output  1  one-cycle pulse on normal completion
oError  output  1  one-cycle pulse on TX timeout

Behaviour:
- Reset (async, active-high): all outputs 0, oFrame = 0, state IDLE, CRC register 0, counters 0.
- Standard frame S[47:0]: S[47]=0 (start), S[46]=1 (transmission), S[45:40]=index, S[39:8]=argument, S[7:1]=CRC7, S[0]=1 (end). oFrame[k] = S[47-k], so bit 0 goes out first.
- CRC7: polynomial x^7+x^3+1, init 0, over S[47:8] MSB first, BITS_PER_CYCLE bits per cycle.
- FSM IDLE -> CRC -> VALID -> IDLE.
- IDLE: iStart=1 latches index and argument, clears CRC, goes to CRC. oBusy rises the next cycle.
- CRC: runs 40/BITS_PER_CYCLE cycles, then loads oFrame and enters VALID. With BITS_PER_CYCLE=1, iStart accepted at edge 0 gives oFrame_Valid=1 after edge 41.
- VALID: oFrame_Valid=1 and oFrame held constant. On iTx_Complete=1: go to IDLE, oFrame_Valid=0, oDone pulses for 1 cycle, and oFrame keeps its last value.
- Timeout: if TX_TIMEOUT>0 and TX_TIMEOUT cycles pass in VALID without iTx_Complete, go to IDLE and pulse oError for 1 cycle.
- iStart outside IDLE is ignored and not queued.
- iTx_Complete outside VALID is ignored.
- iTx_Complete on the same cycle the timeout would expire: completion wins (oDone, no oError).
- Back-to-back frames: iStart in the cycle after oDone is accepted. Minimum frame period is 40/BITS_PER_CYCLE + 2 cycles plus the serializer time.
- Reset mid-operation: immediate return to IDLE, no oDone/oError pulse, and the latched command is discarded.

Optional Feature:
CMD_FRAME_BUILDER_CRC_OVERRIDE_EN.
- Defined: adds input iCrc_Override (1) and input iCrc_Value (7), both latched with iStart. If the latched override is 1, CRC lasts exactly 1 cycle and S[7:1]=iCrc_Value. Used for error injection and for commands with a precomputed CRC.
- Undefined: these ports do not exist and the CRC is always computed.

Decomposition:
- Shared package cmd_pkg:
  - CMD_FRAME_W=48, CMD_CRC_SPAN=40
  - CRC7_POLY=7'h09
  - START_BIT=0, TX_BIT=1, END_BIT=1
  - FSM state typedef {IDLE, CRC, VALID}
- One sub-module, crc7_serial: combinational next-state of CRC7 for N input bits, instantiated by the builder with N=BITS_PER_CYCLE.

Test Plan:
- CMD0, arg 0x00000000 -> S = 0x40_00000000_95; oFrame = bit-reverse of S; oFrame_Valid high 41 cycles after iStart (BITS_PER_CYCLE=1); iTx_Complete -> oDone pulse, oBusy low.
- CMD8, arg 0x000001AA -> CRC7 = 0x43, S[7:0] = 0x87; repeat with BITS_PER_CYCLE=8 -> oFrame_Valid after 6 cycles, identical frame.
- iStart pulsed during CRC and during VALID -> ignored; exactly one oDone; next iStart in the cycle after oDone accepted and produces a correct frame.
- TX_TIMEOUT=10, no iTx_Complete -> oError pulse 10 cycles after oFrame_Valid rises, oFrame_Valid=0; iTx_Complete on the expiry cycle -> oDone only.
- Assert iReset in the middle of CRC and again in VALID -> all outputs 0 immediately, no oDone/oError; a following CMD0 is built correctly.
- With CMD_FRAME_BUILDER_CRC_OVERRIDE_EN defined, iCrc_Override=1, iCrc_Value=0x00 on CMD0 -> S[7:0]=0x01, oFrame_Valid 2 cycles after iStart.
